// File: rtl/int_mul_pipe.sv
// ---------------------------------------------------------------------------
// int_mul_pipe
//   Fully pipelined integer multiplier for the River integer pipeline.
//   Handles MUL / MULH / MULHU / MULHSU / MULW with independent operand
//   signedness, one operation per cycle, with writeback tag, flush and
//   output backpressure.
//
//   Pipeline: S0 conditioning, S1 partial products, S2 group reduction,
//   S3 final sum/negation, then the registered result selection
//   (o_res/o_tag). An op accepted at edge N is presented after edge N+4.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), synchronous active-high reset
//   i_valid / o_ready     request handshake
//   i_a1, i_a2            operands (XLEN)
//   i_unsign_a1/a2        per-operand unsigned flags
//   i_high                return upper XLEN bits of the product
//   i_rv32                32-bit word op (ignored when XLEN=32)
//   i_tag                 opaque tag returned with the result
//   i_flush               kill all in-flight operations
//   o_valid / i_resp_ready result handshake
//   o_res, o_tag          result and its tag
//   o_chk_err             sticky reference-check mismatch
//
// Optional feature macro: INT_MUL_REFCHECK_EN
//   When defined, a behavioural reference result travels with every op and
//   is compared against o_res; a mismatch sets o_chk_err. When undefined,
//   o_chk_err is tied to 0.
// ---------------------------------------------------------------------------
module int_mul_pipe #(
    parameter int XLEN    = 64,
    parameter int DIGIT_W = 4,
    parameter int TAG_W   = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [XLEN-1:0]  i_a1,
    input  logic [XLEN-1:0]  i_a2,
    input  logic             i_unsign_a1,
    input  logic             i_unsign_a2,
    input  logic             i_high,
    input  logic             i_rv32,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_resp_ready,
    output logic [XLEN-1:0]  o_res,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_chk_err
);

    localparam int NUM_PP   = XLEN / DIGIT_W;
    localparam int PP_PER_G = NUM_PP / 4;
    localparam int PP_W     = XLEN + DIGIT_W + 1;
    localparam int GS_W     = 2*XLEN - (3*XLEN/4) + DIGIT_W + 3;
    localparam int G_SHIFT  = XLEN / 4;
    localparam int P_W      = 2 * XLEN;

    logic stall, advance, accept;

    // The whole pipe freezes when the consumer refuses a presented result.
    assign stall   = o_valid && !i_resp_ready;
    assign advance = !stall;
    assign o_ready = !stall && !i_flush;
    assign accept  = i_valid && o_ready;

    // ---------------- S0: operand conditioning ----------------
    logic [XLEN-1:0] a1_x, a2_x, abs1, abs2;
    logic            rv32_eff, neg1, neg2;

    generate
        if (XLEN == 64) begin : g_word_ops
            // Word ops reduce each operand to its low 32 bits, extended per signedness.
            always_comb begin
                rv32_eff = i_rv32;
                a1_x     = i_a1;
                a2_x     = i_a2;
                if (i_rv32) begin
                    a1_x = i_unsign_a1 ? {32'b0, i_a1[31:0]} : {{32{i_a1[31]}}, i_a1[31:0]};
                    a2_x = i_unsign_a2 ? {32'b0, i_a2[31:0]} : {{32{i_a2[31]}}, i_a2[31:0]};
                end
            end
        end else begin : g_no_word_ops
            always_comb begin
                rv32_eff = 1'b0;
                a1_x     = i_a1;
                a2_x     = i_a2;
            end
        end
    endgenerate

    assign neg1 = !i_unsign_a1 && a1_x[XLEN-1];
    assign neg2 = !i_unsign_a2 && a2_x[XLEN-1];
    // The most negative value maps to 2^(XLEN-1), which still fits unsigned.
    assign abs1 = neg1 ? (-a1_x) : a1_x;
    assign abs2 = neg2 ? (-a2_x) : a2_x;

    logic             s0_valid, s0_inv, s0_zero, s0_rv32, s0_high;
    logic [XLEN-1:0]  s0_abs1, s0_abs2;
    logic [TAG_W-1:0] s0_tag;

    // ---------------- S1: partial products ----------------
    logic [PP_W-1:0]  pp_next [NUM_PP];
    logic [PP_W-1:0]  s1_pp   [NUM_PP];
    logic             s1_valid, s1_inv, s1_zero, s1_rv32, s1_high;
    logic [TAG_W-1:0] s1_tag;

    always_comb begin
        for (int k = 0; k < NUM_PP; k++) begin
            pp_next[k] = PP_W'(s0_abs1) * PP_W'(s0_abs2[k*DIGIT_W +: DIGIT_W]);
        end
    end

    // ---------------- S2: reduction into four groups ----------------
    // Each entry is weighted by its digit position inside its own group;
    // the group weight itself is applied in S3.
    logic [GS_W-1:0]  gs_next [4];
    logic [GS_W-1:0]  s2_gs   [4];
    logic             s2_valid, s2_inv, s2_zero, s2_rv32, s2_high;
    logic [TAG_W-1:0] s2_tag;

    always_comb begin
        for (int g = 0; g < 4; g++) begin
            gs_next[g] = '0;
            for (int j = 0; j < PP_PER_G; j++) begin
                gs_next[g] = gs_next[g] + (GS_W'(s1_pp[g*PP_PER_G + j]) << (j*DIGIT_W));
            end
        end
    end

    // ---------------- S3: final sum, sign and zero fix-up ----------------
    logic [P_W-1:0]   mag, prod_next, s3_prod;
    logic             s3_valid, s3_rv32, s3_high;
    logic [TAG_W-1:0] s3_tag;

    always_comb begin
        mag = '0;
        for (int g = 0; g < 4; g++) begin
            mag = mag + (P_W'(s2_gs[g]) << (g*G_SHIFT));
        end
        prod_next = s2_inv ? (-mag) : mag;
        if (s2_zero) begin
            prod_next = '0;
        end
    end

    // ---------------- Result selection ----------------
    logic [XLEN-1:0] res_next;

    generate
        if (XLEN == 64) begin : g_sel64
            always_comb begin
                if (s3_rv32)      res_next = {{32{s3_prod[31]}}, s3_prod[31:0]};
                else if (s3_high) res_next = s3_prod[P_W-1:XLEN];
                else              res_next = s3_prod[XLEN-1:0];
            end
        end else begin : g_sel32
            always_comb begin
                if (s3_high) res_next = s3_prod[P_W-1:XLEN];
                else         res_next = s3_prod[XLEN-1:0];
            end
        end
    endgenerate

    // Valid bits: flush and reset win over a stall.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            s0_valid <= 1'b0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            o_valid  <= 1'b0;
        end else if (advance) begin
            s0_valid <= accept;
            s1_valid <= s0_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            o_valid  <= s3_valid;
        end
    end

    // Datapath registers; contents of bubble stages are don't-care.
    always_ff @(posedge i_clk) begin
        if (advance) begin
            s0_abs1 <= abs1;
            s0_abs2 <= abs2;
            s0_inv  <= neg1 ^ neg2;
            s0_zero <= (a1_x == '0) || (a2_x == '0);
            s0_rv32 <= rv32_eff;
            s0_high <= i_high;
            s0_tag  <= i_tag;

            s1_pp   <= pp_next;
            s1_inv  <= s0_inv;
            s1_zero <= s0_zero;
            s1_rv32 <= s0_rv32;
            s1_high <= s0_high;
            s1_tag  <= s0_tag;

            s2_gs   <= gs_next;
            s2_inv  <= s1_inv;
            s2_zero <= s1_zero;
            s2_rv32 <= s1_rv32;
            s2_high <= s1_high;
            s2_tag  <= s1_tag;

            s3_prod <= prod_next;
            s3_rv32 <= s2_rv32;
            s3_high <= s2_high;
            s3_tag  <= s2_tag;
        end
    end

    // Output registers hold while stalled, so o_res/o_tag stay stable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_res <= '0;
            o_tag <= '0;
        end else if (advance) begin
            o_res <= res_next;
            o_tag <= s3_tag;
        end
    end

`ifdef INT_MUL_REFCHECK_EN
    logic signed [P_W+1:0] ref_op1, ref_op2, ref_full;
    logic [XLEN-1:0]       ref_next, s0_ref, s1_ref, s2_ref, s3_ref, out_ref;
    logic                  chk_err_q;

    // Behavioural reference using the native multiplier on extended operands.
    always_comb begin
        ref_op1  = (P_W+2)'($signed({!i_unsign_a1 && a1_x[XLEN-1], a1_x}));
        ref_op2  = (P_W+2)'($signed({!i_unsign_a2 && a2_x[XLEN-1], a2_x}));
        ref_full = ref_op1 * ref_op2;
        if (rv32_eff)    ref_next = XLEN'($signed(ref_full[31:0]));
        else if (i_high) ref_next = ref_full[P_W-1:XLEN];
        else             ref_next = ref_full[XLEN-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (advance) begin
            s0_ref  <= ref_next;
            s1_ref  <= s0_ref;
            s2_ref  <= s1_ref;
            s3_ref  <= s2_ref;
            out_ref <= s3_ref;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            chk_err_q <= 1'b0;
        end else if (o_valid && (o_res != out_ref)) begin
            chk_err_q <= 1'b1;
            $error("int_mul_pipe: result 0x%h differs from reference 0x%h", o_res, out_ref);
        end
    end

    assign o_chk_err = chk_err_q;
`else
    assign o_chk_err = 1'b0;
`endif

endmodule
